// File: rtl/parallel_link_ctrl.sv
// Link bring-up sequencer for the parallel TX/RX pair: CLR hold, training,
// lock timeout, error-window monitoring and bounded retrain with back-off.
//
// Ports:
//   CLK, RST          clock, asynchronous active-high reset
//   EN                1 = bring link up and keep it up, 0 = shut down
//   RX_LOCKED         receiver word alignment achieved (synchronous level)
//   RX_ERR            one-cycle pulse per received data word mismatch
//   TX_CLR, RX_CLR    CLR to parallel sender / receiver
//   LINK_UP, FAIL     state flags (UP / FAILED)
//   RETRY_CNT         retrains performed this session
//   ERR_CNT           saturating count of RX_ERR pulses seen while UP
module parallel_link_ctrl #(
    parameter int CLR_CYCLES     = 4,
    parameter int TRAIN_TIMEOUT  = 4096,
    parameter int BACKOFF_CYCLES = 64,
    parameter int WIN_CYCLES     = 1024,
    parameter int ERR_LIMIT      = 16,
    parameter int MAX_RETRY      = 8
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        EN,
    input  logic        RX_LOCKED,
    input  logic        RX_ERR,
    output logic        TX_CLR,
    output logic        RX_CLR,
    output logic        LINK_UP,
    output logic        FAIL,
    output logic [3:0]  RETRY_CNT,
    output logic [15:0] ERR_CNT
);

    typedef enum logic [2:0] {
        IDLE, CLEAR, TRAIN, UP, BACKOFF, FAILED
    } state_t;

    localparam logic [15:0] CLR_LD   = 16'(CLR_CYCLES - 1);
    localparam logic [15:0] TRAIN_LD = 16'(TRAIN_TIMEOUT - 1);
    localparam logic [15:0] BOFF_LD  = 16'(BACKOFF_CYCLES - 1);
    localparam logic [15:0] WIN_LD   = 16'(WIN_CYCLES - 1);
    localparam logic [16:0] ERR_LIM  = 17'(ERR_LIMIT);
    localparam logic [3:0]  RETRY_MX = 4'(MAX_RETRY);

    state_t      state, state_n;
    logic [15:0] timer, timer_n;
    logic [15:0] win_err, win_err_n;
    logic [15:0] err_cnt_n;
    logic [3:0]  retry_n;
    logic [16:0] win_inc;
    logic        retry_go;
    logic        expired;

    assign expired = (timer == 16'd0);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            timer     <= 16'd0;
            win_err   <= 16'd0;
            ERR_CNT   <= 16'd0;
            RETRY_CNT <= 4'd0;
        end else begin
            state     <= state_n;
            timer     <= timer_n;
            win_err   <= win_err_n;
            ERR_CNT   <= err_cnt_n;
            RETRY_CNT <= retry_n;
        end
    end

    always_comb begin
        state_n   = state;
        timer_n   = expired ? timer : timer - 16'd1;
        win_err_n = win_err;
        err_cnt_n = ERR_CNT;
        retry_n   = RETRY_CNT;
        win_inc   = {1'b0, win_err};
        retry_go  = 1'b0;

        unique case (state)
            IDLE: begin
                retry_n   = 4'd0;
                err_cnt_n = 16'd0;
                if (EN) begin
                    state_n = CLEAR;
                    timer_n = CLR_LD;
                end
            end
            CLEAR: begin
                if (expired) begin
                    state_n = TRAIN;
                    timer_n = TRAIN_LD;
                end
            end
            TRAIN: begin
                // Lock wins over a coincident timeout.
                if (RX_LOCKED) begin
                    state_n   = UP;
                    timer_n   = WIN_LD;
                    win_err_n = 16'd0;
                end else if (expired) begin
                    retry_go = 1'b1;
                end
            end
            UP: begin
                // An error on the window-expiry cycle opens the new window.
                win_inc   = {1'b0, expired ? 16'd0 : win_err}
                          + 17'(RX_ERR);
                win_err_n = win_inc[15:0];
                if (expired)
                    timer_n = WIN_LD;
                if (RX_ERR && ERR_CNT != 16'hFFFF)
                    err_cnt_n = ERR_CNT + 16'd1;
                if (!RX_LOCKED || (RX_ERR && win_inc >= ERR_LIM))
                    retry_go = 1'b1;
            end
            BACKOFF: begin
                if (expired) begin
                    state_n = TRAIN;
                    timer_n = TRAIN_LD;
                end
            end
            FAILED: begin
                timer_n = 16'd0;
            end
            default: begin
                state_n = IDLE;
                timer_n = 16'd0;
            end
        endcase

        if (retry_go) begin
            if (RETRY_CNT == RETRY_MX) begin
                state_n = FAILED;
                timer_n = 16'd0;
            end else begin
                state_n = BACKOFF;
                timer_n = BOFF_LD;
                retry_n = RETRY_CNT + 4'd1;
            end
        end

        // Shutdown overrides everything and returns to reset values.
        if (!EN) begin
            state_n   = IDLE;
            timer_n   = 16'd0;
            win_err_n = 16'd0;
            err_cnt_n = 16'd0;
            retry_n   = 4'd0;
        end
    end

    assign TX_CLR  = (state != TRAIN) && (state != UP);
    assign RX_CLR  = TX_CLR;
    assign LINK_UP = (state == UP);
    assign FAIL    = (state == FAILED);

endmodule
